// File: rtl/aes_demo_top.sv
// AES demo sequencer: fixed-key AES-128/192/256 encrypt then decrypt of a fixed message,
// showing the low result byte in decimal on three seven-segment digits.
package aes_demo_pkg;
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; zero maps to zero as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] x2, x3, x12, x240;
        x2   = gf_mul(a, a);
        x3   = gf_mul(x2, a);
        x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
        x240 = gf_mul(x12, x3);
        for (int i = 0; i < 4; i++) x240 = gf_mul(x240, x240);
        return gf_mul(gf_mul(x240, x12), x2);
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
        return (a << n) | (a >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return gf_inv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        for (int k = 0; k < 16; k++)
            o[8*k +: 8] = inv ? inv_sbox(s[8*k +: 8]) : sbox(s[8*k +: 8]);
        return o;
    endfunction

    // State bytes are column-major from the MSB: byte (c,r) sits at index 4c+r.
    function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        int src;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                src = inv ? (c - r + 4) % 4 : (c + r) % 4;
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*src+r) -: 8];
            end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        logic [7:0]   m [4];
        logic [7:0]   acc;
        m[0] = inv ? 8'h0e : 8'h02;
        m[1] = inv ? 8'h0b : 8'h03;
        m[2] = inv ? 8'h0d : 8'h01;
        m[3] = inv ? 8'h09 : 8'h01;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gf_mul(s[127-8*(4*c+j) -: 8], m[(j - r + 4) % 4]);
                o[127-8*(4*c+r) -: 8] = acc;
            end
        return o;
    endfunction
endpackage

module key_expansion #(parameter int NK = 4, parameter int NR = 10) (
    input  logic [32*NK-1:0]      key_i,
    output logic [NR:0][127:0]    round_keys_o
);
    import aes_demo_pkg::*;

    function automatic logic [NR:0][127:0] expand(input logic [32*NK-1:0] key);
        logic [31:0]           w [4*(NR+1)];
        logic [31:0]           t;
        logic [7:0]            rc;
        logic [NR:0][127:0]    rk;
        rc = 8'h01;
        for (int i = 0; i < 4*(NR+1); i++) begin
            if (i < NK) begin
                w[i] = key[32*(NK-1-i) +: 32];
            end else begin
                t = w[i-1];
                if (i % NK == 0) begin
                    t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                    rc = xt(rc);
                end else if (NK > 6 && i % NK == 4) begin
                    t = sub_word(t);
                end
                w[i] = w[i-NK] ^ t;
            end
        end
        for (int r = 0; r <= NR; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return rk;
    endfunction

    assign round_keys_o = expand(key_i);
endmodule

// Iterative cipher core, one round per clock; restarts whenever its input word changes.
module aes_core #(parameter int NR = 10, parameter bit DEC = 1'b0) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [127:0]          din_i,
    input  logic [NR:0][127:0]    round_keys_i,
    output logic [127:0]          dout_o
);
    import aes_demo_pkg::*;

    localparam logic [3:0] LAST      = 4'(NR);
    localparam int         FIRST_KEY = DEC ? NR : 0;

    logic [127:0] state_q, state_d, din_q;
    logic [3:0]   round_q, key_idx;

    always_comb begin
        key_idx = DEC ? LAST - round_q : round_q;
        if (DEC) begin
            state_d = sub_bytes(shift_rows(state_q, 1'b1), 1'b1) ^ round_keys_i[key_idx];
            if (round_q != LAST) state_d = mix_columns(state_d, 1'b1);
        end else begin
            state_d = shift_rows(sub_bytes(state_q, 1'b0), 1'b0);
            if (round_q != LAST) state_d = mix_columns(state_d, 1'b0);
            state_d = state_d ^ round_keys_i[key_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= '0;
            din_q   <= '0;
            round_q <= '0;
        end else if (round_q == 4'd0 || din_i != din_q) begin
            din_q   <= din_i;
            round_q <= 4'd1;
            state_q <= din_i ^ round_keys_i[FIRST_KEY];
        end else if (round_q <= LAST) begin
            state_q <= state_d;
            round_q <= round_q + 4'd1;
        end
    end

    assign dout_o = state_q;
endmodule

module aes_demo_top #(
    parameter logic [127:0] MESSAGE = 128'h00112233445566778899aabbccddeeff,
    parameter logic [127:0] KEY128  = 128'h000102030405060708090a0b0c0d0e0f,
    parameter logic [191:0] KEY192  = 192'h000102030405060708090a0b0c0d0e0f1011121314151617,
    parameter logic [255:0] KEY256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] SW,
    output logic [6:0] HEX2,
    output logic [6:0] HEX1,
    output logic [6:0] HEX0,
    output logic       led
);
    logic         core_rst;
    logic [127:0] enc_out [3];
    logic [127:0] dec_out [3];
    logic [4:0]   cnt_q, cnt_d, enc_end, dec_end;
    logic [127:0] disp_q, disp_d;
    logic         led_q, led_d;
    logic [1:0]   sel;
    logic [7:0]   v;

    assign core_rst = ~reset;

    for (genvar gi = 0; gi < 3; gi++) begin : g_size
        localparam int NK = 4 + 2*gi;
        localparam int NR = 10 + 2*gi;
        logic [32*NK-1:0]   key;
        logic [NR:0][127:0] rk;

        if (gi == 0) begin : g_k128
            assign key = KEY128;
        end else if (gi == 1) begin : g_k192
            assign key = KEY192;
        end else begin : g_k256
            assign key = KEY256;
        end

        key_expansion #(.NK(NK), .NR(NR)) u_kexp (.key_i(key), .round_keys_o(rk));
        aes_core #(.NR(NR), .DEC(1'b0)) u_enc (
            .clk(clk), .rst(core_rst), .din_i(MESSAGE), .round_keys_i(rk), .dout_o(enc_out[gi]));
        aes_core #(.NR(NR), .DEC(1'b1)) u_dec (
            .clk(clk), .rst(core_rst), .din_i(enc_out[gi]), .round_keys_i(rk), .dout_o(dec_out[gi]));
    end

    // Encrypt phase spans counts 1..Nr+1, decrypt phase Nr+2..2Nr+2 (Nr = 8 + 2*SW).
    always_comb begin
        cnt_d   = cnt_q;
        disp_d  = disp_q;
        sel     = SW - 2'd1;
        enc_end = 5'd9 + {2'b00, SW, 1'b0};
        dec_end = {enc_end[3:0], 1'b0};
        if (SW == 2'b00) begin
            disp_d = '0;
            if (cnt_q != 5'd31) cnt_d = cnt_q + 5'd1;
        end else if (cnt_q == 5'd0) begin
            disp_d = MESSAGE;
            cnt_d  = 5'd1;
        end else if (cnt_q <= enc_end) begin
            disp_d = enc_out[sel];
            cnt_d  = cnt_q + 5'd1;
        end else begin
            disp_d = dec_out[sel];
            if (cnt_q <= dec_end) cnt_d = cnt_q + 5'd1;
        end
        led_d = (cnt_q >= 5'd20) && (disp_d == MESSAGE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            disp_q <= '0;
            led_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            disp_q <= disp_d;
            led_q  <= led_d;
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7f;
        endcase
    endfunction

    assign v    = disp_q[7:0];
    assign HEX2 = seg7(4'(v / 8'd100));
    assign HEX1 = seg7(4'((v / 8'd10) % 8'd10));
    assign HEX0 = seg7(4'(v % 8'd10));
    assign led  = led_q;
endmodule

// File: tb/tb_aes_demo_top.sv
// Bench for aes_demo_top: directed vector table, hand-built reset/mode sequences and a
// randomized run against a counter/phase model of the sequencer.
module tb_aes_demo_top;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] SW = 2'b01;
    logic [6:0] HEX2, HEX1, HEX0;
    logic       led;

    int checks = 0;
    int errors = 0;

    logic [6:0] seg_tab [10];
    int         ct_low [4];

    typedef struct {
        logic [1:0] sw;
        int         n;
        int         val;
        logic       led;
    } vec_t;
    vec_t vecs [12];

    always #5 clk = ~clk;

    aes_demo_top dut (
        .clk(clk), .reset(reset), .SW(SW),
        .HEX2(HEX2), .HEX1(HEX1), .HEX0(HEX0), .led(led)
    );

    function automatic logic [20:0] hex_of(input int val);
        return {seg_tab[val / 100], seg_tab[(val / 10) % 10], seg_tab[val % 10]};
    endfunction

    task automatic check(input string name, input int val, input logic exp_led);
        logic [20:0] e;
        e = hex_of(val);
        checks++;
        if ({HEX2, HEX1, HEX0} !== e) begin
            errors++;
            $display("FAIL %s: HEX2/1/0=%h/%h/%h, expected %h/%h/%h (value %0d)",
                     name, HEX2, HEX1, HEX0, e[20:14], e[13:7], e[6:0], val);
        end
        checks++;
        if (led !== exp_led) begin
            errors++;
            $display("FAIL %s led: got %b expected %b", name, led, exp_led);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int  cnt_m, e_m, nr, cnt_pre, val, rnd_checked;
    bit  known, is_msg;
    logic exp_led;

    initial begin
        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        ct_low  = '{0, 'h5a, 'h91, 'h89};
        vecs[0]  = '{2'b01,  1, 255, 1'b0};
        vecs[1]  = '{2'b01, 12,  90, 1'b0};
        vecs[2]  = '{2'b01, 23, 255, 1'b1};
        vecs[3]  = '{2'b01, 40, 255, 1'b1};
        vecs[4]  = '{2'b10,  1, 255, 1'b0};
        vecs[5]  = '{2'b10, 14, 145, 1'b0};
        vecs[6]  = '{2'b10, 27, 255, 1'b1};
        vecs[7]  = '{2'b11, 16, 137, 1'b0};
        vecs[8]  = '{2'b11, 31, 255, 1'b1};
        vecs[9]  = '{2'b11, 45, 255, 1'b1};
        vecs[10] = '{2'b00,  3,   0, 1'b0};
        vecs[11] = '{2'b00, 40,   0, 1'b0};

        #12;
        check("reset state", 0, 1'b0);
        $display("reset: HEX=%h/%h/%h led=%b", HEX2, HEX1, HEX0, led);

        for (int i = 0; i < 12; i++) begin
            SW = vecs[i].sw;
            pulse_reset();
            edges(vecs[i].n);
            check($sformatf("vec%0d sw=%b n=%0d", i, vecs[i].sw, vecs[i].n), vecs[i].val, vecs[i].led);
            $display("vec%0d: SW=%b edges=%0d HEX=%h/%h/%h led=%b", i, vecs[i].sw, vecs[i].n,
                     HEX2, HEX1, HEX0, led);
        end

        // Blank mode saturates the counter; switching to AES-128 lands straight in decrypt hold.
        SW = 2'b00;
        pulse_reset();
        edges(40);
        SW = 2'b01;
        edges(1);
        check("sw00 then sw01", 255, 1'b1);
        $display("sw00->sw01: HEX=%h/%h/%h led=%b", HEX2, HEX1, HEX0, led);

        // Asynchronous reset between edges, then restart from count 0.
        SW = 2'b11;
        pulse_reset();
        edges(9);
        #2;
        reset = 1'b0;
        #1;
        check("async reset", 0, 1'b0);
        $display("async reset: HEX=%h/%h/%h led=%b", HEX2, HEX1, HEX0, led);
        @(negedge clk);
        reset = 1'b1;
        edges(1);
        check("restart first edge", 255, 1'b0);
        edges(15);
        check("restart ciphertext", 137, 1'b0);
        $display("restart: HEX=%h/%h/%h led=%b", HEX2, HEX1, HEX0, led);

        // Randomized mode switches and resets against the phase model.
        pulse_reset();
        cnt_m = 0;
        e_m = 0;
        rnd_checked = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            reset = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 19) == 0) SW = 2'($urandom_range(0, 3));
            if (!reset) begin
                known = 1; val = 0; exp_led = 1'b0; cnt_m = 0; e_m = 0;
            end else begin
                cnt_pre = cnt_m;
                nr = 8 + 2 * int'(SW);
                is_msg = 0;
                if (SW == 2'b00) begin
                    known = 1; val = 0;
                    if (cnt_m < 31) cnt_m++;
                end else if (cnt_m == 0) begin
                    known = 1; val = 255; is_msg = 1; cnt_m = 1;
                end else if (cnt_m <= nr + 1) begin
                    known = (e_m >= nr + 1); val = ct_low[SW]; cnt_m++;
                end else begin
                    known = (e_m >= 2 * nr + 2); val = 255; is_msg = 1;
                    if (cnt_m <= 2 * nr + 2) cnt_m++;
                end
                exp_led = (cnt_pre >= 20) && is_msg;
                if (e_m < 1000) e_m++;
            end
            @(posedge clk);
            #1;
            if (known) begin
                check($sformatf("random cyc%0d sw=%b", cyc, SW), val, exp_led);
                rnd_checked++;
            end
            @(negedge clk);
        end
        $display("random: %0d cycles checked", rnd_checked);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
